// File: rtl/multi_bank_song_memory.sv
// Banked song store: per-bank append writes, sequential playback with optional
// loop-around in AUTOPLAY, and end-of-song flagging against each bank's length.
module multi_bank_song_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 64,
  parameter int NUM_BANKS   = 4,
  parameter int STATE_WIDTH = 2,
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STATE_WIDTH-1:0] current_state,
  input  logic [BANK_W-1:0]      bank_sel,
  input  logic                   write_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   clear_bank,
  input  logic                   read_en,
  input  logic                   read_rst,
  input  logic                   loop_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   output_ready,
  output logic                   end_of_song,
  output logic [ADDR_W:0]        bank_len,
  output logic                   full
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0]       DEPTH_LEN   = LEN_W'(DEPTH);
  localparam logic [STATE_WIDTH-1:0] ST_AUTOPLAY = '0;
  localparam logic [STATE_WIDTH-1:0] ST_LEARNING = STATE_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    mem [NUM_BANKS*DEPTH];
  logic [LEN_W-1:0]         len [NUM_BANKS];
  logic [LEN_W-1:0]         rptr_reg;
  logic [BANK_W-1:0]        bank_prev_reg;
  logic                     active_prev_reg;
  logic [LEN_W-1:0]         sel_len;
  logic                     active;
  logic                     rewind;
  logic                     write_ok;
  logic                     read_ok;
  logic                     last_word;
  logic                     wrap;
  logic [BANK_W+ADDR_W-1:0] waddr;
  logic [BANK_W+ADDR_W-1:0] raddr;

  assign sel_len   = len[bank_sel];
  assign bank_len  = sel_len;
  assign full      = (sel_len == DEPTH_LEN);
  assign active    = (current_state == ST_AUTOPLAY) || (current_state == ST_LEARNING);
  assign rewind    = read_rst || (bank_sel != bank_prev_reg) || (active && !active_prev_reg);
  assign write_ok  = write_en && !clear_bank && !full;
  // Read compares against the pre-write length, so a word written this cycle is
  // only visible from the next cycle on.
  assign read_ok   = active && !rewind && !clear_bank && read_en && (rptr_reg < sel_len);
  assign last_word = ((rptr_reg + LEN_W'(1)) == sel_len);
  assign wrap      = (current_state == ST_AUTOPLAY) && loop_en;
  assign waddr     = {bank_sel, sel_len[ADDR_W-1:0]};
  assign raddr     = {bank_sel, rptr_reg[ADDR_W-1:0]};

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [LEN_W-1:0] len_reg;
      logic             hit;

      assign hit = (bank_sel == BANK_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          len_reg <= '0;
        end else if (hit && clear_bank) begin
          len_reg <= '0;
        end else if (hit && write_ok) begin
          len_reg <= len_reg + LEN_W'(1);
        end
      end

      assign len[gi] = len_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[waddr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_reg        <= '0;
      end_of_song     <= 1'b0;
      data_out        <= '0;
      output_ready    <= 1'b0;
      bank_prev_reg   <= '0;
      active_prev_reg <= 1'b0;
    end else begin
      bank_prev_reg   <= bank_sel;
      active_prev_reg <= active;
      output_ready    <= read_ok;
      if (clear_bank || !active || rewind) begin
        rptr_reg    <= '0;
        end_of_song <= 1'b0;
      end else if (read_en) begin
        if (read_ok) begin
          data_out <= mem[raddr];
          if (last_word && wrap) begin
            rptr_reg    <= '0;
            end_of_song <= 1'b0;
          end else if (last_word) begin
            rptr_reg    <= sel_len;
            end_of_song <= 1'b1;
          end else begin
            rptr_reg <= rptr_reg + LEN_W'(1);
          end
        end else begin
          // Reading past the end: flag only if there is a song at all.
          end_of_song <= (sel_len != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_bank_song_memory.sv
// Bench for multi_bank_song_memory: directed scenarios plus random traffic,
// every cycle compared against a per-bank song-list model.
module tb_multi_bank_song_memory;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int NB    = 4;
  localparam int SW    = 2;
  localparam int BW    = 2;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] current_state;
  logic [BW-1:0] bank_sel;
  logic          write_en;
  logic [DW-1:0] data_in;
  logic          clear_bank;
  logic          read_en;
  logic          read_rst;
  logic          loop_en;
  logic [DW-1:0] data_out;
  logic          output_ready;
  logic          end_of_song;
  logic [AW:0]   bank_len;
  logic          full;

  multi_bank_song_memory #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_BANKS  (NB),
    .STATE_WIDTH(SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .current_state(current_state),
    .bank_sel     (bank_sel),
    .write_en     (write_en),
    .data_in      (data_in),
    .clear_bank   (clear_bank),
    .read_en      (read_en),
    .read_rst     (read_rst),
    .loop_en      (loop_en),
    .data_out     (data_out),
    .output_ready (output_ready),
    .end_of_song  (end_of_song),
    .bank_len     (bank_len),
    .full         (full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each bank is a list of words plus its length.
  logic [DW-1:0] song_mem [NB][DEPTH];
  int            song_len [NB];
  int            rp;
  bit            m_eos;
  bit            m_rdy;
  logic [DW-1:0] m_dout;
  int            prev_bs;
  bit            prev_act;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) song_len[b] = 0;
    rp       = 0;
    m_eos    = 1'b0;
    m_rdy    = 1'b0;
    m_dout   = '0;
    prev_bs  = 0;
    prev_act = 1'b0;
  endtask

  task automatic model_edge(input int st, input int bs, input bit we, input logic [DW-1:0] din,
                            input bit clr, input bit re, input bit rr, input bit le);
    bit act;
    bit rew;
    int n;
    act   = (st == 0) || (st == 1);
    rew   = rr || (bs != prev_bs) || (act && !prev_act);
    n     = song_len[bs];
    m_rdy = 1'b0;
    if (clr) begin
      song_len[bs] = 0;
      rp           = 0;
      m_eos        = 1'b0;
    end else begin
      if (!act || rew) begin
        rp    = 0;
        m_eos = 1'b0;
      end else if (re) begin
        if (rp < n) begin
          m_dout = song_mem[bs][rp];
          m_rdy  = 1'b1;
          rp++;
          if (rp == n) begin
            if (st == 0 && le) rp = 0;
            else m_eos = 1'b1;
          end
        end else begin
          m_eos = (n > 0);
        end
      end
      if (we && n < DEPTH) begin
        song_mem[bs][n] = din;
        song_len[bs]    = n + 1;
      end
    end
    prev_bs  = bs;
    prev_act = act;
  endtask

  // One clock cycle: drive at the falling edge, check length outputs, then
  // check registered outputs 1 time unit after the rising edge.
  task automatic step(input int st, input int bs, input bit we, input logic [DW-1:0] din,
                      input bit clr, input bit re, input bit rr, input bit le);
    current_state = SW'(st);
    bank_sel      = BW'(bs);
    write_en      = we;
    data_in       = din;
    clear_bank    = clr;
    read_en       = re;
    read_rst      = rr;
    loop_en       = le;
    #1;
    check_value("bank_len", 32'(bank_len), 32'(song_len[bs]));
    check_value("full", 32'(full), 32'(song_len[bs] == DEPTH));
    @(posedge clk);
    model_edge(st, bs, we, din, clr, re, rr, le);
    #1;
    check_value("output_ready", 32'(output_ready), 32'(m_rdy));
    check_value("data_out", 32'(data_out), 32'(m_dout));
    check_value("end_of_song", 32'(end_of_song), 32'(m_eos));
    $display("st=%0d bank=%0d we=%0b din=%h clr=%0b re=%0b rr=%0b le=%0b -> rdy=%0b dout=%h eos=%0b len=%0d",
             st, bs, we, din, clr, re, rr, le, output_ready, data_out, end_of_song, bank_len);
    @(negedge clk);
  endtask

  initial begin
    int r;
    int st;
    int bs;
    rst_n         = 1'b0;
    current_state = 2'b10;
    bank_sel      = '0;
    write_en      = 1'b0;
    data_in       = '0;
    clear_bank    = 1'b0;
    read_en       = 1'b0;
    read_rst      = 1'b0;
    loop_en       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_value("reset_data_out", 32'(data_out), 32'h0);
    check_value("reset_output_ready", 32'(output_ready), 32'h0);
    check_value("reset_end_of_song", 32'(end_of_song), 32'h0);
    check_value("reset_bank_len", 32'(bank_len), 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of operation.
    for (int i = 0; i < 3; i++) step(2, 1, 1, DW'(16'h0a01 + i), 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check_value("mid_read_word", 32'(data_out), 32'h0a01);
    #2 rst_n = 1'b0;
    #1;
    check_value("async_data_out", 32'(data_out), 32'h0);
    check_value("async_output_ready", 32'(output_ready), 32'h0);
    check_value("async_end_of_song", 32'(end_of_song), 32'h0);
    check_value("async_bank_len", 32'(bank_len), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Three-word song on bank 2, AUTOPLAY without loop.
    step(2, 2, 1, 16'h0011, 0, 0, 0, 0);
    step(2, 2, 1, 16'h0022, 0, 0, 0, 0);
    step(2, 2, 1, 16'h0033, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2, 0, 0, 0, 1, 0, 0);
    check_value("song_end_flag", 32'(end_of_song), 32'h1);
    check_value("song_last_word", 32'(data_out), 32'h0033);

    // Loop-around in AUTOPLAY, then LEARNING ignoring loop_en.
    step(0, 2, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 2, 0, 0, 0, 1, 0, 1);
    check_value("loop_word5", 32'(data_out), 32'h0022);
    step(1, 2, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 0, 1, 0, 1);
    check_value("learning_stop", 32'(end_of_song), 32'h1);

    // Fill bank 0, then one dropped write, then read back in LEARNING.
    for (int i = 0; i < DEPTH; i++) step(2, 0, 1, DW'($urandom), 0, 0, 0, 0);
    check_value("full_flag", 32'(full), 32'h1);
    check_value("full_len", 32'(bank_len), 32'(DEPTH));
    step(2, 0, 1, 16'hdead, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 0, 0, 1, 0, 0);

    // Bank switch and read_rst.
    for (int i = 0; i < 4; i++) step(2, 1, 1, DW'(16'hb100 + i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check_value("switch_word0", 32'(data_out), 32'hb100);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check_value("rewind_word0", 32'(data_out), 32'hb100);

    // Idle state read, clear+write, empty-bank read.
    step(2, 1, 0, 0, 0, 1, 0, 0);
    step(0, 3, 1, 16'h3333, 1, 0, 0, 0);
    step(0, 3, 0, 0, 0, 1, 0, 0);
    check_value("empty_eos", 32'(end_of_song), 32'h0);

    // Random traffic.
    st = 0;
    bs = 0;
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 7);
      st = (r < 3) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : 3;
      if ($urandom_range(0, 7) == 0) bs = $urandom_range(0, NB - 1);
      step(st, bs, ($urandom_range(0, 2) == 0), DW'($urandom), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
